decode_queue: RTL and testbench

DECODE_QUEUE -- requirements
Module: decode_queue

---
 rtl/decode_queue.sv | 209 ++++++++++++++++++++
 tb/tb_decode_queue.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_queue.sv
// Decode queue: a DEPTH-entry FIFO of {pc, instr} between fetch and decode,
// presenting combinationally decoded control signals for the head entry.
module decode_queue #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_flush,
    input  logic            i_vld,
    output logic            o_rdy,
    input  logic [31:0]     i_instr,
    input  logic [XLEN-1:0] i_pc,
    output logic            o_vld,
    input  logic            i_rdy,
    output logic [31:0]     o_instr,
    output logic [XLEN-1:0] o_pc,
    output logic            o_rd_wren,
    output logic            o_mem_wren,
    output logic            o_op_a_sel,
    output logic            o_op_b_sel,
    output logic            o_br_sel,
    output logic            o_br_unsigned,
    output logic            o_l_unsigned,
    output logic            o_insn_vld,
    output logic [1:0]      o_wb_sel,
    output logic [1:0]      o_s_length,
    output logic [2:0]      o_l_length,
    output logic [3:0]      o_alu_op,
    output logic [AW:0]     o_level,
    output logic            o_trap
);

    typedef enum logic [3:0] {
        ALU_ADD    = 4'b0000,
        ALU_SUB    = 4'b0001,
        ALU_SLT    = 4'b0010,
        ALU_SLTU   = 4'b0011,
        ALU_XOR    = 4'b0100,
        ALU_OR     = 4'b0101,
        ALU_AND    = 4'b0110,
        ALU_SLL    = 4'b0111,
        ALU_SRL    = 4'b1000,
        ALU_SRA    = 4'b1001,
        ALU_PASS_B = 4'b1010
    } alu_op_e;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [AW:0] LEVEL_FULL = (AW+1)'(DEPTH);

    logic [XLEN-1:0] pc_mem    [DEPTH];
    logic [31:0]     instr_mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     level;
    logic            push, pop;
    logic [31:0]     head;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            alt;

    assign o_level = level;
    assign o_rdy   = (level != LEVEL_FULL);
    assign o_vld   = (level != '0);
    assign push    = i_vld && o_rdy && !i_flush;
    assign pop     = o_vld && i_rdy && !i_flush;

    // NOTE: the entry storage carries no reset; pointers and level alone say which slots are live.
    always_ff @(posedge i_clk) begin
        if (push) begin
            instr_mem[wr_ptr] <= i_instr;
            pc_mem[wr_ptr]    <= i_pc;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            o_trap <= 1'b0;
        end else if (i_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            o_trap <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            if (pop && !o_insn_vld) o_trap <= 1'b1;
        end
    end

    // Empty queue presents an all-zero head, which decodes as illegal with every field 0.
    assign head    = o_vld ? instr_mem[rd_ptr] : 32'h0;
    assign o_instr = head;
    assign o_pc    = o_vld ? pc_mem[rd_ptr] : '0;
    assign opcode  = head[6:0];
    assign funct3  = head[14:12];
    assign alt     = head[30];

    function automatic logic [3:0] alu_sel(input logic [2:0] f3, input logic alt_bit,
                                           input logic sub_ok);
        case (f3)
            3'b000:  alu_sel = (alt_bit && sub_ok) ? ALU_SUB : ALU_ADD;
            3'b001:  alu_sel = ALU_SLL;
            3'b010:  alu_sel = ALU_SLT;
            3'b011:  alu_sel = ALU_SLTU;
            3'b100:  alu_sel = ALU_XOR;
            3'b101:  alu_sel = alt_bit ? ALU_SRA : ALU_SRL;
            3'b110:  alu_sel = ALU_OR;
            default: alu_sel = ALU_AND;
        endcase
    endfunction

    // NOTE: every output gets a default first, so no path through the case can infer a latch.
    always_comb begin
        o_rd_wren     = 1'b0;
        o_mem_wren    = 1'b0;
        o_op_a_sel    = 1'b0;
        o_op_b_sel    = 1'b0;
        o_br_sel      = 1'b0;
        o_br_unsigned = 1'b0;
        o_l_unsigned  = 1'b0;
        o_insn_vld    = 1'b0;
        o_wb_sel      = 2'b00;
        o_s_length    = 2'b00;
        o_l_length    = 3'b000;
        o_alu_op      = ALU_ADD;
        case (opcode)
            OP_R: begin
                o_insn_vld = 1'b1;
                o_rd_wren  = 1'b1;
                o_alu_op   = alu_sel(funct3, alt, 1'b1);
            end
            OP_IMM: begin
                o_insn_vld = 1'b1;
                o_rd_wren  = 1'b1;
                o_op_b_sel = 1'b1;
                o_alu_op   = alu_sel(funct3, alt, 1'b0);
            end
            OP_LOAD: begin
                o_insn_vld   = 1'b1;
                o_rd_wren    = 1'b1;
                o_op_b_sel   = 1'b1;
                o_wb_sel     = 2'b01;
                o_l_length   = funct3;
                o_l_unsigned = (funct3 == 3'b100) || (funct3 == 3'b101);
            end
            OP_STORE: begin
                o_insn_vld = 1'b1;
                o_op_b_sel = 1'b1;
                o_mem_wren = 1'b1;
                o_s_length = funct3[1:0];
            end
            OP_BRANCH: begin
                o_insn_vld    = 1'b1;
                o_op_a_sel    = 1'b1;
                o_op_b_sel    = 1'b1;
                o_br_sel      = 1'b1;
                o_br_unsigned = funct3[2] & funct3[1];
            end
            OP_JAL: begin
                o_insn_vld = 1'b1;
                o_op_a_sel = 1'b1;
                o_op_b_sel = 1'b1;
                o_wb_sel   = 2'b10;
                o_rd_wren  = 1'b1;
                o_br_sel   = 1'b1;
            end
            OP_JALR: begin
                o_insn_vld = 1'b1;
                o_op_b_sel = 1'b1;
                o_wb_sel   = 2'b10;
                o_rd_wren  = 1'b1;
                o_br_sel   = 1'b1;
            end
            OP_LUI: begin
                o_insn_vld = 1'b1;
                o_op_b_sel = 1'b1;
                o_rd_wren  = 1'b1;
                o_alu_op   = ALU_PASS_B;
            end
            OP_AUIPC: begin
                o_insn_vld = 1'b1;
                o_op_a_sel = 1'b1;
                o_op_b_sel = 1'b1;
                o_rd_wren  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_decode_queue.sv
// Self-checking bench for decode_queue: directed scenarios plus random traffic,
// all compared against a queue-based reference model every cycle.
module tb_decode_queue;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic            i_clk = 1'b0;
    logic            i_rst, i_flush, i_vld, i_rdy;
    logic [31:0]     i_instr;
    logic [XLEN-1:0] i_pc;
    logic            o_rdy, o_vld, o_trap;
    logic [31:0]     o_instr;
    logic [XLEN-1:0] o_pc;
    logic            o_rd_wren, o_mem_wren, o_op_a_sel, o_op_b_sel, o_br_sel;
    logic            o_br_unsigned, o_l_unsigned, o_insn_vld;
    logic [1:0]      o_wb_sel, o_s_length;
    logic [2:0]      o_l_length;
    logic [3:0]      o_alu_op;
    logic [AW:0]     o_level;

    decode_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .AW(AW)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_flush(i_flush), .i_vld(i_vld), .o_rdy(o_rdy),
        .i_instr(i_instr), .i_pc(i_pc), .o_vld(o_vld), .i_rdy(i_rdy),
        .o_instr(o_instr), .o_pc(o_pc), .o_rd_wren(o_rd_wren), .o_mem_wren(o_mem_wren),
        .o_op_a_sel(o_op_a_sel), .o_op_b_sel(o_op_b_sel), .o_br_sel(o_br_sel),
        .o_br_unsigned(o_br_unsigned), .o_l_unsigned(o_l_unsigned), .o_insn_vld(o_insn_vld),
        .o_wb_sel(o_wb_sel), .o_s_length(o_s_length), .o_l_length(o_l_length),
        .o_alu_op(o_alu_op), .o_level(o_level), .o_trap(o_trap)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic rd, mem, a, b, br, bru, lu, iv;
        logic [1:0] wb, sl;
        logic [2:0] ll;
        logic [3:0] alu;
    } ctl_t;

    typedef struct {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
    } entry_t;

    entry_t q[$];
    logic   trap_m;
    int     n_total = 0;
    int     n_bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference decode built straight from the opcode table and ALU rules.
    function automatic ctl_t ref_decode(input logic [31:0] ins);
        ctl_t c;
        logic [6:0] opc;
        logic [2:0] f3;
        logic [6:0] tbl;
        logic [3:0] base;
        c   = '0;
        opc = ins[6:0];
        f3  = ins[14:12];
        tbl = 7'b0;
        case (f3)
            0: base = 0;  1: base = 7; 2: base = 2; 3: base = 3;
            4: base = 4;  5: base = 8; 6: base = 5; default: base = 6;
        endcase
        case (opc)
            7'h33: tbl = 7'b0_0_00_1_0_0;
            7'h13: tbl = 7'b0_1_00_1_0_0;
            7'h03: tbl = 7'b0_1_01_1_0_0;
            7'h23: tbl = 7'b0_1_00_0_1_0;
            7'h63: tbl = 7'b1_1_00_0_0_1;
            7'h6F: tbl = 7'b1_1_10_1_0_1;
            7'h67: tbl = 7'b0_1_10_1_0_1;
            7'h37: tbl = 7'b0_1_00_1_0_0;
            7'h17: tbl = 7'b1_1_00_1_0_0;
            default: return c;
        endcase
        c.iv = 1'b1;
        {c.a, c.b, c.wb, c.rd, c.mem, c.br} = tbl;
        if (opc == 7'h33 || opc == 7'h13) begin
            c.alu = base;
            if (ins[30] && f3 == 3'd5) c.alu = 4'd9;
            if (ins[30] && f3 == 3'd0 && opc == 7'h33) c.alu = 4'd1;
        end
        if (opc == 7'h37) c.alu = 4'd10;
        if (opc == 7'h03) begin
            c.ll = f3;
            c.lu = (f3 == 3'd4 || f3 == 3'd5);
        end
        if (opc == 7'h23) c.sl = f3[1:0];
        if (opc == 7'h63) c.bru = (f3 >= 3'd6);
        return c;
    endfunction

    function automatic ctl_t dut_ctl();
        return {o_rd_wren, o_mem_wren, o_op_a_sel, o_op_b_sel, o_br_sel, o_br_unsigned,
                o_l_unsigned, o_insn_vld, o_wb_sel, o_s_length, o_l_length, o_alu_op};
    endfunction

    task automatic compare_all();
        check("level", 64'(o_level), 64'(q.size()));
        check("rdy", 64'(o_rdy), 64'(q.size() != DEPTH));
        check("vld", 64'(o_vld), 64'(q.size() != 0));
        check("trap", 64'(o_trap), 64'(trap_m));
        if (q.size() != 0) begin
            check("instr", 64'(o_instr), 64'(q[0].instr));
            check("pc", 64'(o_pc), 64'(q[0].pc));
            check("ctl", 64'(dut_ctl()), 64'(ref_decode(q[0].instr)));
        end else begin
            check("instr_empty", 64'(o_instr), 64'h0);
            check("pc_empty", 64'(o_pc), 64'h0);
            check("ctl_empty", 64'(dut_ctl()), 64'h0);
        end
    endtask

    // One clock cycle: check state, drive inputs, advance the model at the edge.
    task automatic step(input logic vld, input logic [31:0] ins, input logic [XLEN-1:0] pc,
                        input logic rdy, input logic flush);
        logic do_push, do_pop;
        compare_all();
        i_vld   = vld;
        i_instr = ins;
        i_pc    = pc;
        i_rdy   = rdy;
        i_flush = flush;
        @(posedge i_clk);
        if (flush) begin
            q.delete();
            trap_m = 1'b0;
        end else begin
            do_pop  = (q.size() != 0) && rdy;
            do_push = vld && (q.size() != DEPTH);
            if (do_pop) begin
                if (!ref_decode(q[0].instr).iv) trap_m = 1'b1;
                void'(q.pop_front());
            end
            if (do_push) q.push_back('{instr: ins, pc: pc});
        end
        @(negedge i_clk);
        i_vld   = 1'b0;
        i_rdy   = 1'b0;
        i_flush = 1'b0;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0]  opcs [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
        logic [31:0] r;
        int k;
        r = $urandom();
        k = $urandom_range(0, 9);
        if (k < 9) r[6:0] = opcs[k];
        return r;
    endfunction

    initial begin
        q.delete();
        trap_m  = 1'b0;
        i_rst   = 1'b1;
        i_flush = 1'b0;
        i_vld   = 1'b0;
        i_rdy   = 1'b0;
        i_instr = '0;
        i_pc    = '0;
        #1;
        compare_all();
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;

        // First push shows up one cycle later, decoded as ADDI.
        step(1'b1, 32'h00500093, 32'h0, 1'b0, 1'b0);
        check("addi_vld", 64'(o_vld), 64'd1);
        check("addi_alu", 64'(o_alu_op), 64'd0);
        check("addi_opb", 64'(o_op_b_sel), 64'd1);
        check("addi_rdw", 64'(o_rd_wren), 64'd1);
        check("addi_iv", 64'(o_insn_vld), 64'd1);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Five pushes into a stalled queue; the fifth must bounce.
        for (int i = 0; i < 5; i++) step(1'b1, rand_instr(), 32'(i * 4), 1'b0, 1'b0);
        check("full_level", 64'(o_level), 64'd4);
        check("full_rdy", 64'(o_rdy), 64'd0);
        step(1'b1, 32'h00000013, 32'h100, 1'b1, 1'b0);
        check("full_pop_no_push", 64'(o_level), 64'd3);
        for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Level 2, then ten simultaneous push/pop cycles.
        for (int i = 0; i < 2; i++) step(1'b1, rand_instr(), 32'h200 + 32'(i), 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b1, rand_instr(), 32'h300 + 32'(i), 1'b1, 1'b0);
        check("steady_level", 64'(o_level), 64'd2);

        // Flush with a concurrent push on a full queue.
        for (int i = 0; i < 4; i++) step(1'b1, rand_instr(), 32'h400 + 32'(i), 1'b0, 1'b0);
        step(1'b1, 32'h00000033, 32'h500, 1'b1, 1'b1);
        check("flush_level", 64'(o_level), 64'd0);
        check("flush_vld", 64'(o_vld), 64'd0);

        // Illegal instruction raises a sticky trap until flush.
        step(1'b1, 32'hFFFFFFFF, 32'h600, 1'b0, 1'b0);
        check("ill_iv", 64'(o_insn_vld), 64'd0);
        check("ill_rdw", 64'(o_rd_wren), 64'd0);
        check("ill_memw", 64'(o_mem_wren), 64'd0);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        check("trap_set", 64'(o_trap), 64'd1);
        for (int i = 0; i < 3; i++) step(1'b1, 32'h00000013, 32'h700, 1'b1, 1'b0);
        check("trap_hold", 64'(o_trap), 64'd1);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        check("trap_clear", 64'(o_trap), 64'd0);

        // SUB, LW, BGEU in sequence.
        step(1'b1, 32'h40B50533, 32'h800, 1'b0, 1'b0);
        step(1'b1, 32'h0000A103, 32'h804, 1'b0, 1'b0);
        step(1'b1, 32'h00C5F463, 32'h808, 1'b0, 1'b0);
        check("sub_alu", 64'(o_alu_op), 64'b0001);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        check("lw_len", 64'(o_l_length), 64'b010);
        check("lw_wb", 64'(o_wb_sel), 64'b01);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        check("bgeu_uns", 64'(o_br_unsigned), 64'd1);
        check("bgeu_br", 64'(o_br_sel), 64'd1);

        // Asynchronous reset while entries are queued, flush held high too.
        step(1'b1, rand_instr(), 32'h900, 1'b0, 1'b0);
        i_flush = 1'b1;
        i_rst   = 1'b1;
        #1;
        q.delete();
        trap_m = 1'b0;
        compare_all();
        @(negedge i_clk);
        i_rst   = 1'b0;
        i_flush = 1'b0;

        // Random traffic.
        for (int i = 0; i < 1500; i++)
            step($urandom_range(0, 9) < 7, rand_instr(), $urandom(),
                 $urandom_range(0, 9) < 6, $urandom_range(0, 49) == 0);
        compare_all();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
